os_tx_generator: RTL
====================

// Module: os_tx_generator
// PURPOSE
//  Transmit-side ordered-set generator for Gen1/Gen2 (8b/10b) links, the counterpart of the RX OS decoder.
//  Under TX LTSSM control it builds TS1/TS2/EIOS/logical-idle symbols per lane into PIPE-format TxData/TxDataK.
//  Its output feeds the TX scrambler, which is bypassed for K symbols and TS data, and then the PIPE TX lanes.
// PARAMETERS
//  PIPEWIDTH     32    bits per lane per clk (8/16/32); SYMS = PIPEWIDTH/8 symbols per lane per clk
//  MAXLANES      16    physical lanes
//  N_FTS         8'hFF FTS count advertised in TS symbol 3
//  SKP_INTERVAL  1180  clks between SKP insertions (OS_TX_SKP_EN only)
// PORTS
//  clk            in   1    clock
//  reset          in   1    synchronous active-high reset
//  GEN            in   3    current generation; only 1 and 2 are accepted
//  numberOfDetectedLanes in 5 active lanes (1..16), sampled at request accept
//  os_req         in   1    request; accepted only in IDLE
//  os_type        in   2    0=TS1 1=TS2 2=EIOS 3=logical idle (D0.0)
//  os_count       in   11   number of OS to send; 0 = continuous until os_stop
//  os_stop        in   1    end continuous send after current OS
//  pad_mode       in   1    1: link/lane symbols = PAD (K23.7)
//  linkNumber     in   8    TS symbol 1 when pad_mode=0
//  rateid         in   8    TS symbol 4
//  os_ack         out  1    1-cycle pulse: request accepted
//  os_err         out  1    1-cycle pulse: request rejected (GEN>=3 or lanes==0)
//  busy           out  1    FSM not in IDLE
//  done           out  1    1-cycle pulse after last symbol of last OS
//  sent_count     out  11   OS completed since accept; saturates at 2047
//  TxData         out  512  lane i at [i*32+:32], symbol k of cycle at [8k+:8]
//  TxDataK        out  64   lane i at [i*4+:4]
//  TxDataValid    out  16   1 on active lanes while sending
//  TxElecIdle     out  16   1 on inactive lanes, and on all lanes in IDLE after EIOS
// BEHAVIOUR
//  Reset: all outputs 0 except TxElecIdle=16'hFFFF; FSM=IDLE.
//  FSM IDLE->SEND on accepted os_req; SEND->IDLE after the last symbol (count reached, or os_stop seen); ->IDLE on reset.
//  Accept latches type/count/link/rateid/pad/lanes; os_ack same cycle; first symbols registered next cycle.
//  os_req while busy: ignored, no ack, no err.
//  TS layout: 0 COM BC(K), 1 link or F7(K), 2 lane index or F7(K), 3 N_FTS, 4 rateid, 5 8'h00, 6-15 4A(TS1)/45(TS2).
//  TS: 16 symbols = 16/SYMS clks. EIOS: BC,7C,7C,7C all K. Idle OS: SYMS zero symbols, K=0.
//  Symbol index advances by SYMS per clk and wraps at OS length; sent_count increments at wrap.
//  os_stop takes effect at the next OS boundary and never truncates an OS. os_stop with os_req: exactly one OS is sent.
//  PIPEWIDTH<32: unused upper bytes of each lane slice are 0 and their K bits are 0; inactive lanes are all 0.
//  After EIOS completes: TxElecIdle=all 1 until the next accept. Otherwise active lanes show 0 in IDLE.
//  done asserts on the cycle after the final symbol beat.
// CONFIGURATION
//  OS_TX_SKP_EN defined: a clk counter reaching SKP_INTERVAL sets skp_pending.
//    At the next OS boundary in SEND, insert SKP OS BC,1C,1C,1C (all K), not counted in sent_count.
//    Then clear the counter. Pending state is held through IDLE.
//  OS_TX_SKP_EN undefined: no counter; SKP is never emitted.
// STRUCTURE
//  Package pcie_tx_os_pkg holds:
//    symbol constants: COM=8'hBC PAD=8'hF7 IDL=8'h7C SKP=8'h1C TS1_ID=8'h4A TS2_ID=8'h45
//    os_type encodings and FSM state encodings.
//  Sub-module os_tx_symbol_mux: combinational (type, symbol index, lane, link, rateid, pad) -> {byte, K}.
//    Instantiated per lane and per symbol slot.
// TESTING
//  Reset: hold reset 2 clks -> TxData=0, TxDataK=0, TxDataValid=0, TxElecIdle=16'hFFFF, busy=0.
//  PIPEWIDTH=32, lanes=2, TS1, count=2, pad=1, rateid=02:
//    lanes 0,1 beats 32'hFFF7F7BC/K=0111, 32'h4A4A0002/K=0, 32'h4A4A4A4A x2; repeated; done at clk 9; sent_count=2.
//  TS2, pad=0, link=01, count=1:
//    lane1 beat0 32'hFF0101BC/K=0001, lane0 beat0 32'hFF0001BC; beats2-3 32'h45454545.
//  count=0 continuous TS1, os_stop at beat 5 -> OS ending beat 7 completes; done next clk; sent_count=2.
//  EIOS, lanes=4: lanes 0-3 one beat 32'h7C7C7CBC/K=1111, then TxElecIdle=16'hFFFF.
//  GEN=3 request -> os_err=1, os_ack=0, busy stays 0.
//  Reset asserted mid-TS -> next clk outputs at reset values.
//  With OS_TX_SKP_EN, SKP_INTERVAL=10 -> SKP beat 32'h1C1C1CBC/K=1111 inserted at the next TS boundary.

Source files
------------

// File: rtl/pcie_tx_os_pkg.sv
// Shared symbol constants, encodings and request payload for the TX ordered-set generator.
package pcie_tx_os_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] IDL    = 8'h7C;
  localparam logic [7:0] SKP    = 8'h1C;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  localparam int unsigned SYM_IDX_W = 4;
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned LANES_W   = 5;

  typedef enum logic [1:0] {
    OS_TS1  = 2'd0,
    OS_TS2  = 2'd1,
    OS_EIOS = 2'd2,
    OS_LIDL = 2'd3
  } os_type_e;

  // Symbol source selection; SKP exists only as an inserted OS, never requested.
  typedef enum logic [2:0] {
    SYM_TS1  = 3'd0,
    SYM_TS2  = 3'd1,
    SYM_EIOS = 3'd2,
    SYM_LIDL = 3'd3,
    SYM_SKP  = 3'd4
  } sym_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    os_type_e             os_type;
    logic [CNT_W-1:0]     count;
    logic [7:0]           link;
    logic [7:0]           rateid;
    logic                 pad;
    logic [LANES_W-1:0]   lanes;
  } os_cfg_t;

  function automatic sym_kind_e os_kind(input os_type_e t);
    case (t)
      OS_TS1:  os_kind = SYM_TS1;
      OS_TS2:  os_kind = SYM_TS2;
      OS_EIOS: os_kind = SYM_EIOS;
      default: os_kind = SYM_LIDL;
    endcase
  endfunction

  // OS length in symbols; logical idle is one beat wide.
  function automatic logic [4:0] os_len(input sym_kind_e kind, input logic [4:0] syms);
    case (kind)
      SYM_TS1, SYM_TS2: os_len = 5'd16;
      SYM_LIDL:         os_len = syms;
      default:          os_len = 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/os_tx_symbol_mux.sv
// Combinational symbol/K selection for one lane and one symbol slot of an ordered set.
module os_tx_symbol_mux
  import pcie_tx_os_pkg::*;
#(
  parameter logic [7:0] N_FTS = 8'hFF
) (
  input  sym_kind_e              kind,
  input  logic [SYM_IDX_W-1:0]   sym_idx,
  input  logic [3:0]             lane,
  input  logic [7:0]             link,
  input  logic [7:0]             rateid,
  input  logic                   pad,
  output logic [7:0]             sym_c,
  output logic                   k_c
);

  always_comb begin
    sym_c = 8'h00;
    k_c   = 1'b0;
    case (kind)
      SYM_TS1, SYM_TS2: begin
        case (sym_idx)
          4'd0: begin
            sym_c = COM;
            k_c   = 1'b1;
          end
          4'd1: begin
            sym_c = pad ? PAD : link;
            k_c   = pad;
          end
          4'd2: begin
            sym_c = pad ? PAD : {4'h0, lane};
            k_c   = pad;
          end
          4'd3:    sym_c = N_FTS;
          4'd4:    sym_c = rateid;
          4'd5:    sym_c = 8'h00;
          default: sym_c = (kind == SYM_TS1) ? TS1_ID : TS2_ID;
        endcase
      end
      SYM_EIOS: begin
        sym_c = (sym_idx == 4'd0) ? COM : IDL;
        k_c   = 1'b1;
      end
      SYM_SKP: begin
        sym_c = (sym_idx == 4'd0) ? COM : SKP;
        k_c   = 1'b1;
      end
      default: begin
        sym_c = 8'h00;
        k_c   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/os_tx_generator.sv
// TX ordered-set generator (TS1/TS2/EIOS/logical idle) into PIPE TxData/TxDataK per lane.
// Optional SKP OS insertion is enabled by defining OS_TX_SKP_EN.
module os_tx_generator
  import pcie_tx_os_pkg::*;
#(
`ifdef OS_TX_SKP_EN
  parameter int unsigned SKP_INTERVAL = 1180,
`endif
  parameter int unsigned PIPEWIDTH = 32,
  parameter int unsigned MAXLANES  = 16,
  parameter logic [7:0]  N_FTS     = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              GEN,
  input  logic [4:0]              numberOfDetectedLanes,
  input  logic                    os_req,
  input  logic [1:0]              os_type,
  input  logic [10:0]             os_count,
  input  logic                    os_stop,
  input  logic                    pad_mode,
  input  logic [7:0]              linkNumber,
  input  logic [7:0]              rateid,
  output logic                    os_ack,
  output logic                    os_err,
  output logic                    busy,
  output logic                    done,
  output logic [10:0]             sent_count,
  output logic [MAXLANES*32-1:0]  TxData,
  output logic [MAXLANES*4-1:0]   TxDataK,
  output logic [MAXLANES-1:0]     TxDataValid,
  output logic [MAXLANES-1:0]     TxElecIdle
);

  localparam int unsigned SYMS   = PIPEWIDTH / 8;
  localparam int unsigned DATA_W = MAXLANES * 32;
  localparam int unsigned K_W    = MAXLANES * 4;
  localparam logic [4:0]  SYMS5  = 5'(SYMS);

  tx_state_e             state_q, state_d;
  os_cfg_t               cfg_q, cfg_d;
  logic [SYM_IDX_W-1:0]  idx_q, idx_d;
  logic                  skp_q, skp_d;
  logic                  stop_q, stop_d;
  logic [CNT_W-1:0]      sent_q, sent_d;
  logic                  eidle_q, eidle_d;
  logic                  done_q, done_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [MAXLANES-1:0]   valid_q, valid_d;
  logic [MAXLANES-1:0]   elec_q, elec_d;

  logic                  req_ok_c;
  logic                  accept_c;
  logic                  wrap_c;
  logic                  skp_pend_c;
  logic [LANES_W-1:0]    lanes_in_c;
  sym_kind_e             cur_kind_c;
  sym_kind_e             kind_d;

  logic [7:0]            sym_w [MAXLANES][SYMS];
  logic                  k_w   [MAXLANES][SYMS];

  assign req_ok_c   = ((GEN == 3'd1) || (GEN == 3'd2)) && (numberOfDetectedLanes != 5'd0);
  assign accept_c   = !reset && (state_q == ST_IDLE) && os_req && req_ok_c;
  assign os_ack     = accept_c;
  assign os_err     = !reset && (state_q == ST_IDLE) && os_req && !req_ok_c;
  assign lanes_in_c = (numberOfDetectedLanes > 5'(MAXLANES)) ? 5'(MAXLANES) : numberOfDetectedLanes;
  assign cur_kind_c = skp_q ? SYM_SKP : os_kind(cfg_q.os_type);
  assign wrap_c     = ({1'b0, idx_q} + SYMS5) >= os_len(cur_kind_c, SYMS5);

  // Next-state: accept, beat advance, OS boundary handling (count/stop/SKP).
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    skp_d   = skp_q;
    stop_d  = stop_q;
    sent_d  = sent_q;
    eidle_d = eidle_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d       = ST_SEND;
          cfg_d.os_type = os_type_e'(os_type);
          cfg_d.count   = os_count;
          cfg_d.link    = linkNumber;
          cfg_d.rateid  = rateid;
          cfg_d.pad     = pad_mode;
          cfg_d.lanes   = lanes_in_c;
          idx_d         = '0;
          skp_d         = 1'b0;
          stop_d        = os_stop;
          sent_d        = '0;
          eidle_d       = 1'b0;
        end
      end
      default: begin
        if (os_stop) stop_d = 1'b1;
        if (!wrap_c) begin
          idx_d = idx_q + 4'(SYMS);
        end else begin
          idx_d = '0;
          if (skp_q) begin
            skp_d = 1'b0;
            if (stop_d) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
              eidle_d = (cfg_q.os_type == OS_EIOS);
            end
          end else begin
            sent_d = (sent_q == '1) ? sent_q : sent_q + 11'd1;
            if (stop_d || ((cfg_q.count != '0) && ((sent_q + 11'd1) == cfg_q.count))) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
              eidle_d = (cfg_q.os_type == OS_EIOS);
            end else if (skp_pend_c) begin
              skp_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign kind_d = skp_d ? SYM_SKP : os_kind(cfg_d.os_type);

  for (genvar l = 0; l < MAXLANES; l++) begin : g_lane
    for (genvar s = 0; s < SYMS; s++) begin : g_sym
      os_tx_symbol_mux #(.N_FTS(N_FTS)) u_mux (
        .kind    (kind_d),
        .sym_idx (idx_d + 4'(s)),
        .lane    (4'(l)),
        .link    (cfg_d.link),
        .rateid  (cfg_d.rateid),
        .pad     (cfg_d.pad),
        .sym_c   (sym_w[l][s]),
        .k_c     (k_w[l][s])
      );
    end
  end

  // Lane output assembly for the beat registered at the next edge.
  always_comb begin
    data_d  = '0;
    k_d     = '0;
    valid_d = '0;
    elec_d  = '0;
    for (int l = 0; l < MAXLANES; l++) begin
      valid_d[l] = (state_d == ST_SEND) && (5'(l) < cfg_d.lanes);
      elec_d[l]  = !(5'(l) < cfg_d.lanes) || eidle_d;
      for (int s = 0; s < SYMS; s++) begin
        if (valid_d[l]) begin
          data_d[l*32 + 8*s +: 8] = sym_w[l][s];
          k_d[l*4 + s]            = k_w[l][s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      skp_q   <= 1'b0;
      stop_q  <= 1'b0;
      sent_q  <= '0;
      eidle_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      k_q     <= '0;
      valid_q <= '0;
      elec_q  <= '1;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      skp_q   <= skp_d;
      stop_q  <= stop_d;
      sent_q  <= sent_d;
      eidle_q <= eidle_d;
      done_q  <= done_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      elec_q  <= elec_d;
    end
  end

`ifdef OS_TX_SKP_EN
  localparam int unsigned SKP_CNT_W = $clog2(SKP_INTERVAL + 1);

  logic [SKP_CNT_W-1:0] skp_cnt_q, skp_cnt_d;
  logic                 skp_pend_q, skp_pend_d;

  // Interval counter; cleared when a SKP OS is scheduled, pending survives IDLE.
  always_comb begin
    skp_cnt_d  = skp_cnt_q;
    skp_pend_d = skp_pend_q;
    if (skp_d && !skp_q) begin
      skp_cnt_d  = '0;
      skp_pend_d = 1'b0;
    end else if (skp_cnt_q == SKP_CNT_W'(SKP_INTERVAL)) begin
      skp_pend_d = 1'b1;
    end else begin
      skp_cnt_d = skp_cnt_q + SKP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skp_cnt_q  <= '0;
      skp_pend_q <= 1'b0;
    end else begin
      skp_cnt_q  <= skp_cnt_d;
      skp_pend_q <= skp_pend_d;
    end
  end

  assign skp_pend_c = skp_pend_q;
`else
  assign skp_pend_c = 1'b0;
`endif

  assign busy        = (state_q == ST_SEND);
  assign done        = done_q;
  assign sent_count  = sent_q;
  assign TxData      = data_q;
  assign TxDataK     = k_q;
  assign TxDataValid = valid_q;
  assign TxElecIdle  = elec_q;

endmodule
